// File: rtl/core_pkg.sv
// Shared RV32I core definitions: pcsrc encodings, fetch FSM states, NOP and opcode constants.
// FETCH_MISALIGN_TRAP_EN adds the FAULT state to the fetch FSM.
package core_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned OPC_W   = 7;
  localparam int unsigned PCSRC_W = 2;

  typedef enum logic [PCSRC_W-1:0] {
    PCSRC_PLUS4  = 2'b00,
    PCSRC_BRANCH = 2'b01,
    PCSRC_JAL    = 2'b10,
    PCSRC_JALR   = 2'b11
  } pcsrc_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
`ifdef FETCH_MISALIGN_TRAP_EN
    ST_HOLD  = 2'd2,
    ST_FAULT = 2'd3
`else
    ST_HOLD  = 2'd2
`endif
  } fetch_state_e;

  // addi x0,x0,0
  localparam logic [XLEN-1:0] NOP_ENC = 32'h0000_0013;

  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;

endpackage

// File: rtl/next_pc_gen.sv
// Next-PC mux and adders. With FETCH_MISALIGN_TRAP_EN the raw target is passed through with a
// misalignment flag; otherwise the target is forced word-aligned.
module next_pc_gen
  import core_pkg::*;
(
  input  logic [XLEN-1:0]    pc,
  input  logic [XLEN-1:0]    pc_plus4,
  input  logic [PCSRC_W-1:0] pcsrc,
  input  logic [XLEN-1:0]    imm_ext,
  input  logic [XLEN-1:0]    alu_result,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic               misalign,
`endif
  output logic [XLEN-1:0]    next_pc
);

  logic [XLEN-1:0] target;

  // Branch-taken and jal share the pc-relative adder.
  always_comb begin
    target = pc_plus4;
    case (pcsrc_e'(pcsrc))
      PCSRC_PLUS4:  target = pc_plus4;
      PCSRC_BRANCH: target = pc + imm_ext;
      PCSRC_JAL:    target = pc + imm_ext;
      PCSRC_JALR:   target = alu_result & 32'hFFFF_FFFE;
      default:      target = pc_plus4;
    endcase
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  assign misalign = |target[1:0];
  assign next_pc  = target;
`else
  assign next_pc  = target & 32'hFFFF_FFFC;
`endif

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches one word at a time over a req/ready handshake,
// holds it for the decoder until retire. FETCH_MISALIGN_TRAP_EN enables the misaligned-target FAULT state.
module fetch_unit
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_ENC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [6:0]  op,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  input  logic        retire,
  input  logic [1:0]  pcsrc,
  input  logic [31:0] imm_ext,
  input  logic [31:0] alu_result,
  output logic        fetch_fault
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] next_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic            misalign;
`endif

  assign pc_plus4 = pc_q + 32'd4;

  next_pc_gen u_next_pc_gen (
    .pc         (pc_q),
    .pc_plus4   (pc_plus4),
    .pcsrc      (pcsrc),
    .imm_ext    (imm_ext),
    .alu_result (alu_result),
`ifdef FETCH_MISALIGN_TRAP_EN
    .misalign   (misalign),
`endif
    .next_pc    (next_pc)
  );

  // State and datapath registers; reset abandons any in-flight request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // Next-state and datapath update; instr reverts to NOP once the held word retires.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      ST_IDLE:  state_d = ST_FETCH;
      ST_FETCH: begin
        if (imem_ready) begin
          instr_d = imem_rdata;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (retire) begin
          pc_d    = next_pc;
          instr_d = NOP_INSTR;
          state_d = ST_FETCH;
`ifdef FETCH_MISALIGN_TRAP_EN
          if (misalign) state_d = ST_FAULT;
`endif
        end
      end
      default: state_d = state_q;
    endcase
  end

  // Moore outputs decoded from the state register.
  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    fetch_fault = 1'b0;
    case (state_q)
      ST_FETCH: imem_req    = 1'b1;
      ST_HOLD:  instr_valid = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
      ST_FAULT: fetch_fault = 1'b1;
`endif
      default: ;
    endcase
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign instr     = instr_q;
  assign op        = instr_q[6:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: driver queues expected fetch addresses, monitor checks
// each accepted fetch and each newly held instruction against a bench-side memory model.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [6:0]  op;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        retire;
  logic [1:0]  pcsrc;
  logic [31:0] imm_ext;
  logic [31:0] alu_result;
  logic        fetch_fault;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_addr = 32'h0;
  logic        prev_valid = 1'b0;

  fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0013)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .op          (op),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .instr_valid (instr_valid),
    .retire      (retire),
    .pcsrc       (pcsrc),
    .imm_ext     (imm_ext),
    .alu_result  (alu_result),
    .fetch_fault (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: word content is a function of its address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    mem_word = {a[26:2], (a[2] ? 7'b1101111 : 7'b0110011)};
  endfunction

  assign imem_rdata = imem_req ? mem_word(imem_addr) : 32'hDEAD_BEEF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: accepted fetches and newly held instructions.
  always @(negedge clk) begin
    logic [31:0] w;
    if (rst === 1'b1 && imem_req && imem_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_fetch", imem_addr, 32'hFFFF_FFFF);
      end else begin
        last_addr = exp_q.pop_front();
        chk("fetch_addr", imem_addr, last_addr);
      end
    end
    if (rst === 1'b1 && instr_valid && !prev_valid) begin
      w = mem_word(last_addr);
      chk("held_instr", instr, w);
      chk("held_op", {25'b0, op}, {25'b0, w[6:0]});
      chk("held_pc", pc, last_addr);
    end
    prev_valid = instr_valid;
  end

  // Called from posedge+1 while in FETCH; returns at posedge+1 in HOLD.
  task automatic fetch_one(input int unsigned wait_n, input logic [31:0] addr);
    exp_q.push_back(addr);
    imem_ready = 1'b0;
    repeat (wait_n) begin
      @(negedge clk);
      chk("stall_req", {31'b0, imem_req}, 32'd1);
      chk("stall_addr", imem_addr, addr);
      chk("stall_instr", instr, 32'h0000_0013);
      @(posedge clk); #1;
    end
    imem_ready = 1'b1;
    @(posedge clk); #1;
    imem_ready = 1'b0;
    chk("hold_valid", {31'b0, instr_valid}, 32'd1);
  endtask

  task automatic retire_one(input logic [1:0] sel, input logic [31:0] imm, input logic [31:0] alu);
    pcsrc      = sel;
    imm_ext    = imm;
    alu_result = alu;
    retire     = 1'b1;
    @(posedge clk); #1;
    retire     = 1'b0;
    chk("post_retire_valid", {31'b0, instr_valid}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; imem_ready = 1'b1; retire = 1'b1;
    pcsrc = 2'b00; imm_ext = 32'h0; alu_result = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_pc", pc, 32'h0);
    chk("rst_fault", {31'b0, fetch_fault}, 32'd0);

    // Back-to-back: ready and retire always high.
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    @(negedge clk);
    chk("idle_req", {31'b0, imem_req}, 32'd0);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (k == 5) begin retire = 1'b0; imem_ready = 1'b0; end
      @(negedge clk);
      chk("valid_pattern", {31'b0, instr_valid}, 32'(k & 1));
    end

    // Stalled fetch at 0x10, then relative/jal/jalr targets.
    retire_one(2'b01, 32'h0000_0008, 32'h0);
    fetch_one(3, 32'h0000_0010);
    retire_one(2'b01, 32'h0000_0010, 32'h0);
    fetch_one(0, 32'h0000_0020);
    retire_one(2'b01, 32'hFFFF_FFF8, 32'h0);
    fetch_one(1, 32'h0000_0018);
    retire_one(2'b01, 32'h0000_0008, 32'h0);
    fetch_one(0, 32'h0000_0020);
    retire_one(2'b10, 32'h0000_0100, 32'h0);
    fetch_one(0, 32'h0000_0120);
    retire_one(2'b11, 32'h0, 32'h0000_0205);
    chk("jalr_req", {31'b0, imem_req}, 32'd1);
    chk("jalr_addr", imem_addr, 32'h0000_0204);

    // Reset mid-FETCH with ready low.
    rst = 1'b0;
    #1;
    chk("midrst_req", {31'b0, imem_req}, 32'd0);
    chk("midrst_valid", {31'b0, instr_valid}, 32'd0);
    chk("midrst_pc", pc, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("restart_req", {31'b0, imem_req}, 32'd1);
    chk("restart_addr", imem_addr, 32'h0);
    chk("restart_valid", {31'b0, instr_valid}, 32'd0);
    chk("restart_instr", instr, 32'h0000_0013);
    fetch_one(0, 32'h0);

    // Wrap-around at the top of the address space.
    retire_one(2'b11, 32'h0, 32'hFFFF_FFFD);
    fetch_one(0, 32'hFFFF_FFFC);
    chk("wrap_pc_plus4", pc_plus4, 32'h0);
    retire_one(2'b00, 32'h0, 32'h0);
    fetch_one(0, 32'h0);

    // Misaligned branch target from 0x40.
    retire_one(2'b01, 32'h0000_0040, 32'h0);
    fetch_one(0, 32'h0000_0040);
    retire_one(2'b01, 32'h0000_0002, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
    repeat (3) begin
      @(negedge clk);
      chk("fault_flag", {31'b0, fetch_fault}, 32'd1);
      chk("fault_req", {31'b0, imem_req}, 32'd0);
      chk("fault_valid", {31'b0, instr_valid}, 32'd0);
    end
    chk("fault_pc", pc, 32'h0000_0042);
`else
    fetch_one(0, 32'h0000_0040);
    chk("nofault_flag", {31'b0, fetch_fault}, 32'd0);
`endif

    @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the main opcode decoder in the single-issue RV32I core.
- Owns the PC register and issues one request at a time to instruction memory over a variable-latency handshake.
- Holds the fetched word in an instruction register and presents it, together with its 7-bit opcode field, to the decoder.
- Computes the next PC from the 2-bit pcsrc select once the current instruction retires.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, instruction register contents while no valid instruction is held (addi x0,x0,0)

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous, active-low reset
imem_req  out  1  fetch request; held high until accepted
imem_addr  out  32  fetch address; equals pc, stable while imem_req=1
imem_ready  in  1  memory accepts the request and returns imem_rdata this cycle
imem_rdata  in  32  instruction word, valid when imem_req&imem_ready
instr  out  32  registered instruction
op  out  7  instr[6:0], to decoder
pc  out  32  address of instr
pc_plus4  out  32  pc+4 modulo 2^32, used for link writeback
instr_valid  out  1  instr/op/pc describe a live instruction
retire  in  1  downstream has consumed the current instruction this cycle
pcsrc  in  2  next-PC select, sampled with retire: 00 pc+4, 01 pc+imm_ext (branch taken), 10 pc+imm_ext (jal), 11 alu_result&~1 (jalr)
imm_ext  in  32  sign-extended immediate, sampled with retire
alu_result  in  32  jalr target, sampled with retire
fetch_fault  out  1  misaligned-target fault flag (see Optional Feature)

Behaviour:
- FSM states: IDLE, FETCH, HOLD, FAULT. FAULT exists only with the macro.
- Reset (rst=0, asynchronous):
  - state=IDLE, pc=RESET_PC, instr=NOP_INSTR, instr_valid=0, imem_req=0, fetch_fault=0.
  - Any in-flight request is abandoned; imem_req drops immediately.
- IDLE: unconditionally moves to FETCH on the next edge. The first imem_req is asserted one cycle after reset deasserts.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On an edge with imem_ready=1: instr<=imem_rdata, instr_valid<=1, state<=HOLD.
  - With imem_ready=0 the request stays asserted with an unchanged address; no timeout.
- HOLD:
  - instr_valid=1, imem_req=0; instr, op and pc are stable.
  - On an edge with retire=1: pc<=next_pc, instr_valid<=0, state<=FETCH.
  - Minimum throughput: 2 cycles per instruction (one FETCH cycle with ready, one HOLD cycle with retire).
- retire outside HOLD is ignored. imem_ready while imem_req=0 is ignored; imem_rdata is don't-care.
- Arithmetic:
  - All PC adds are 32-bit with wrap-around: pc=32'hFFFF_FFFC, pcsrc=00 gives 32'h0000_0000.
  - pcsrc 01 and 10 compute the same target; they are kept distinct for the decoder's encoding.
  - For jalr (11), bit 0 of alu_result is cleared.
- op is combinationally instr[6:0]. pc_plus4 is combinational from pc.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined:
  - On retire, if next_pc[1:0]!=0, pc still loads next_pc, instr_valid<=0 and state<=FAULT.
  - In FAULT: fetch_fault=1, imem_req=0. The unit stays in FAULT until reset.
- Undefined:
  - next_pc[1:0] is forced to 2'b00 before loading pc.
  - FAULT state is absent; fetch_fault is tied to 0.

Decomposition:
- Shared package core_pkg:
  - pcsrc encodings PCSRC_PLUS4, PCSRC_BRANCH, PCSRC_JAL, PCSRC_JALR.
  - Fetch FSM state typedef.
  - NOP encoding constant.
  - Opcode constants shared with the decoder.
- One sub-module, next_pc_gen: combinational mux and adders producing next_pc (and the misalignment flag when the macro is set).

Test Plan:
- Reset release, RESET_PC=0, imem_ready=1 constant, retire=1 in every HOLD cycle → imem_req rises 1 cycle after reset; imem_addr sequence 0,4,8; instr_valid high every other cycle.
- imem_ready held low for 3 cycles → imem_req=1 and imem_addr=0x10 stable for 4 cycles; instr captured only on the ready edge.
- HOLD with pcsrc=01, imm_ext=0xFFFF_FFF8, pc=0x20 → next imem_addr=0x18. pcsrc=10, imm_ext=0x100 → 0x120. pcsrc=11, alu_result=0x205 → 0x204.
- pc=0xFFFF_FFFC, pcsrc=00, retire → imem_addr=0x0; pc_plus4 reads 0x0 while in HOLD.
- rst asserted mid-FETCH with imem_ready=0 → imem_req drops the same cycle; after release, fetch restarts at RESET_PC with instr_valid=0 and instr=0x13.
- With FETCH_MISALIGN_TRAP_EN, pcsrc=01, pc=0x40, imm_ext=0x2 → fetch_fault=1, no further imem_req. Without the macro → fetch at 0x40.
